y0_dac_if: RTL and testbench
============================

Name: y0_dac_if

Overview:
- Output stage directly downstream of the ANC datapath top level.
- Consumes the primary-path anti-noise samples (y0_valid/y0_data: 4-level values ±2, ±6) at the datapath sample rate.
- Buffers them in a small FIFO and streams them to an external serial DAC as fixed-rate, MSB-first frames.
- Flags overflow/underrun so firmware can detect rate mismatch between datapath and DAC clock divider.

Parameters:
- IN_W, 4, sample width (matches `Y0_W), two's complement.
- FIFO_DEPTH, 8, sample FIFO entries; power of two, ≥2.
- CLK_DIV, 4, clock cycles per DAC bit; even, ≥2.
- PRIME_LVL, 4, FIFO occupancy required before streaming starts; 1..FIFO_DEPTH.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  streaming enable, level.
- y0_valid_in  in  1  sample strobe, one cycle per sample.
- y0_data_in  in  IN_W  signed sample.
- clear_flags  in  1  one-cycle pulse; clears sticky flags.
- dac_sclk  out  1  DAC bit clock.
- dac_sdata  out  1  serial data, MSB first.
- dac_frame  out  1  high for the MSB bit period of each frame.
- fill_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow_flag  out  1  sticky: sample dropped because the FIFO was full.
- underrun_flag  out  1  sticky: FIFO empty at a frame boundary while running.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, state IDLE, divider=0, bit counter=0, shift register=0. All outputs 0; fill_level=0.
- FIFO push: on y0_valid_in when not full.
  - If full: sample dropped, overflow_flag set the next cycle.
  - Push and pop in the same cycle are both legal. Full+pop+push: push accepted, no overflow.
- Divider: counts 0..CLK_DIV-1 while in RUN or DRAIN; each wrap is a bit boundary. dac_sclk=1 when divider ≥ CLK_DIV/2. Data and frame change on the divider=0 cycle, so the DAC samples on the sclk rising edge.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: outputs 0, divider held at 0.
  - IDLE→RUN: when enable=1 and fill_level ≥ PRIME_LVL. On that cycle the head is popped into the shift register; the first bit (MSB) appears on dac_sdata the next cycle with dac_frame=1.
  - RUN: shift one bit per CLK_DIV cycles. A frame is IN_W bit periods.
  - Last-bit boundary of a frame (divider=CLK_DIV-1, bit=IN_W-1):
    - enable=1, FIFO non-empty: pop next sample; back-to-back frames, no gap.
    - enable=1, FIFO empty: load 0, set underrun_flag. Clocking and framing continue (zero frame).
    - enable=0: go to DRAIN.
  - enable dropping mid-frame: current frame finishes; no truncation.
  - DRAIN: one cycle with sdata=0, frame=0, sclk=0, divider reset; then IDLE. FIFO contents are retained; re-enable needs PRIME_LVL again.
- Flags: set has priority over a simultaneous clear_flags. Flags are cleared only by clear_flags or reset.
- fill_level reflects the registered count; it updates the cycle after a push or pop.
- Width: samples are shifted verbatim; no scaling or saturation.

Decomposition:
- Package y0_dac_pkg: state enum (IDLE, RUN, DRAIN), and localparam helpers for the counter widths ($clog2(CLK_DIV), $clog2(IN_W), $clog2(FIFO_DEPTH)+1).
- Sub-module y0_sync_fifo: parameterised synchronous FIFO (DEPTH, W) with push, pop, full, empty and count outputs, using the same active-low async reset.
- The top block holds the FSM, divider, shift register and flags.

Test Plan (defaults: IN_W=4, CLK_DIV=4, PRIME_LVL=4):
- Prime and stream: push 6, 2, -2, -6 → 1 cycle after the 4th push lands, frames 0110, 0010, 1110, 1010 appear, each bit 4 cycles, 16-cycle frames, dac_frame high on the MSB only.
- Underrun: after the scenario above, no further pushes → a zero frame 0000 follows, underrun_flag=1; a push of 2 during the zero frame → the next frame is 0010.
- Overflow: enable=0, push 9 samples → fill_level=8, overflow_flag=1, the 9th sample is absent from later output; clear_flags → flag 0.
- Simultaneous events: FIFO full, push coincident with frame-boundary pop → no overflow, fill_level stays 8. Overflow set and clear_flags in the same cycle → flag remains 1.
- Disable mid-frame: deassert enable at bit 1 → frame completes to 4 bits, 1 DRAIN cycle, IDLE with outputs 0; the FIFO remainder is preserved.
- Async reset mid-frame: reset low for 1 ns between clock edges → all outputs 0 immediately, fill_level=0; after release, no output until PRIME_LVL samples are pushed.

Source files
------------

// File: rtl/y0_dac_pkg.sv
// Shared types and width helpers for the serial DAC output stage.
package y0_dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int div_w(input int clk_div);
        return (clk_div > 2) ? $clog2(clk_div) : 1;
    endfunction

    function automatic int bit_w(input int in_w);
        return (in_w > 2) ? $clog2(in_w) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/y0_sync_fifo.sv
// Synchronous FIFO, combinational head read; count/full/empty are registered.
// A push while full is accepted only when a pop happens in the same cycle.
module y0_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/y0_dac_if.sv
// Buffers anti-noise samples and streams them MSB-first to a serial DAC in fixed-rate frames.
// First bit appears one cycle after the priming pop; sticky flags report FIFO overflow/underrun.
module y0_dac_if
    import y0_dac_pkg::*;
#(
    parameter int IN_W       = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 4,
    parameter int PRIME_LVL  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          y0_valid_in,
    input  logic [IN_W-1:0]               y0_data_in,
    input  logic                          clear_flags,
    output logic                          dac_sclk,
    output logic                          dac_sdata,
    output logic                          dac_frame,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow_flag,
    output logic                          underrun_flag
);

    localparam int DIV_W = div_w(CLK_DIV);
    localparam int BIT_W = bit_w(IN_W);
    localparam int CNT_W = cnt_w(FIFO_DEPTH);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(IN_W - 1);
    localparam logic [CNT_W-1:0] PRIME_CNT = CNT_W'(PRIME_LVL);

    state_t            state;
    logic [DIV_W-1:0]  div;
    logic [DIV_W-1:0]  div_nxt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [IN_W-1:0]   shreg;

    logic [IN_W-1:0]   fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              start;
    logic              frame_end;
    logic              pop;
    logic              overflow_evt;
    logic              underrun_evt;

    y0_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (IN_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (y0_valid_in),
        .pop   (pop),
        .din   (y0_data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fill_level)
    );

    assign div_nxt      = div + DIV_W'(1);
    assign start        = (state == IDLE) && enable && (fill_level >= PRIME_CNT);
    assign frame_end    = (state == RUN) && (div == DIV_LAST) && (bit_cnt == BIT_LAST);
    assign pop          = start || (frame_end && enable && !fifo_empty);
    assign overflow_evt = y0_valid_in && fifo_full && !pop;
    assign underrun_evt = frame_end && enable && fifo_empty;

    // The shift register MSB is the serial output; it is zero outside RUN.
    assign dac_sdata = shreg[IN_W-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            div       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            dac_frame <= 1'b0;
            dac_sclk  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div      <= '0;
                    bit_cnt  <= '0;
                    dac_sclk <= 1'b0;
                    if (start) begin
                        state     <= RUN;
                        shreg     <= fifo_dout;
                        dac_frame <= 1'b1;
                    end else begin
                        shreg     <= '0;
                        dac_frame <= 1'b0;
                    end
                end
                RUN: begin
                    if (div == DIV_LAST) begin
                        div      <= '0;
                        dac_sclk <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (enable) begin
                                // Empty FIFO streams a zero frame to keep the DAC framing intact.
                                shreg     <= fifo_empty ? '0 : fifo_dout;
                                dac_frame <= 1'b1;
                            end else begin
                                state     <= DRAIN;
                                shreg     <= '0;
                                dac_frame <= 1'b0;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                            shreg     <= {shreg[IN_W-2:0], 1'b0};
                            dac_frame <= 1'b0;
                        end
                    end else begin
                        div      <= div_nxt;
                        dac_sclk <= (div_nxt >= DIV_HALF);
                    end
                end
                DRAIN: begin
                    state     <= IDLE;
                    div       <= '0;
                    bit_cnt   <= '0;
                    shreg     <= '0;
                    dac_frame <= 1'b0;
                    dac_sclk  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    div       <= '0;
                    bit_cnt   <= '0;
                    shreg     <= '0;
                    dac_frame <= 1'b0;
                    dac_sclk  <= 1'b0;
                end
            endcase
        end
    end

    // Setting a flag wins over a coincident clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_flag <= 1'b0;
            underrun_flag <= 1'b0;
        end else begin
            if (overflow_evt) begin
                overflow_flag <= 1'b1;
            end else if (clear_flags) begin
                overflow_flag <= 1'b0;
            end
            if (underrun_evt) begin
                underrun_flag <= 1'b1;
            end else if (clear_flags) begin
                underrun_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_y0_dac_if.sv
// Bench for y0_dac_if: queue-based reference model compared every cycle, plus directed literal checks.
module tb_y0_dac_if;

    localparam int IN_W       = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int CLK_DIV    = 4;
    localparam int PRIME_LVL  = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int FRAME      = IN_W * CLK_DIV;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable = 1'b0;
    logic             y0_valid_in = 1'b0;
    logic [IN_W-1:0]  y0_data_in = '0;
    logic             clear_flags = 1'b0;
    logic             dac_sclk;
    logic             dac_sdata;
    logic             dac_frame;
    logic [CNT_W-1:0] fill_level;
    logic             overflow_flag;
    logic             underrun_flag;

    int checks = 0;
    int errors = 0;

    y0_dac_if #(
        .IN_W       (IN_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CLK_DIV    (CLK_DIV),
        .PRIME_LVL  (PRIME_LVL)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .y0_valid_in   (y0_valid_in),
        .y0_data_in    (y0_data_in),
        .clear_flags   (clear_flags),
        .dac_sclk      (dac_sclk),
        .dac_sdata     (dac_sdata),
        .dac_frame     (dac_frame),
        .fill_level    (fill_level),
        .overflow_flag (overflow_flag),
        .underrun_flag (underrun_flag)
    );

    always #5 clock = ~clock;

    // Reference model: sample queue, mode (0 idle, 1 run, 2 drain), position within the frame.
    logic [IN_W-1:0] q[$];
    int              m_st = 0;
    int              m_t = 0;
    logic [IN_W-1:0] m_cur = '0;
    bit              m_ovf = 0;
    bit              m_udr = 0;

    always @(posedge clock or negedge reset) begin
        int pre;
        bit popped, oset, uset;
        if (!reset) begin
            q.delete();
            m_st = 0; m_t = 0; m_cur = '0; m_ovf = 0; m_udr = 0;
        end else begin
            pre = q.size(); popped = 0; oset = 0; uset = 0;
            if (m_st == 0) begin
                if (enable && pre >= PRIME_LVL) begin
                    m_cur = q.pop_front(); popped = 1; m_st = 1; m_t = 0;
                end
            end else if (m_st == 1) begin
                if (m_t == FRAME - 1) begin
                    if (enable) begin
                        m_t = 0;
                        if (pre > 0) begin m_cur = q.pop_front(); popped = 1; end
                        else begin m_cur = '0; uset = 1; end
                    end else begin
                        m_st = 2;
                    end
                end else begin
                    m_t++;
                end
            end else begin
                m_st = 0;
            end
            if (y0_valid_in) begin
                if (pre < FIFO_DEPTH || popped) q.push_back(y0_data_in);
                else oset = 1;
            end
            if (oset) m_ovf = 1; else if (clear_flags) m_ovf = 0;
            if (uset) m_udr = 1; else if (clear_flags) m_udr = 0;
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clock) begin
        int ph, bi;
        logic e_sclk, e_sdata, e_frame;
        e_sclk = 0; e_sdata = 0; e_frame = 0;
        if (m_st == 1) begin
            ph = m_t % CLK_DIV;
            bi = m_t / CLK_DIV;
            e_sclk  = (ph >= CLK_DIV / 2);
            e_sdata = m_cur[IN_W-1-bi];
            e_frame = (bi == 0);
        end
        checks++;
        if ({dac_sclk, dac_sdata, dac_frame, overflow_flag, underrun_flag} !==
            {e_sclk, e_sdata, e_frame, m_ovf, m_udr} || fill_level !== CNT_W'(q.size())) begin
            errors++;
            $display("FAIL cycle@%0t: got sclk=%b sdata=%b frame=%b fill=%0d ovf=%b udr=%b, want sclk=%b sdata=%b frame=%b fill=%0d ovf=%b udr=%b",
                     $time, dac_sclk, dac_sdata, dac_frame, fill_level, overflow_flag, underrun_flag,
                     e_sclk, e_sdata, e_frame, q.size(), m_ovf, m_udr);
        end
    end

    // Deserialiser: rebuilds frames as the DAC would see them on sclk rising edges.
    logic [IN_W-1:0] got_frames[$];
    logic [IN_W-1:0] acc = '0;
    int              nb = 0;

    always @(posedge dac_sclk or negedge reset) begin
        if (!reset) begin
            nb = 0;
        end else begin
            if (dac_frame) begin
                acc = {{(IN_W-1){1'b0}}, dac_sdata}; nb = 1;
            end else if (nb > 0) begin
                acc = {acc[IN_W-2:0], dac_sdata}; nb++;
            end
            if (nb == IN_W) begin
                got_frames.push_back(acc); nb = 0;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_frame(input string name, input int idx, input int v);
        int got;
        got = (idx < got_frames.size()) ? int'(got_frames[idx]) : -1;
        chk(name, got, v & ((1 << IN_W) - 1));
    endtask

    task automatic push(input int v);
        y0_valid_in = 1'b1;
        y0_data_in  = v[IN_W-1:0];
        @(negedge clock);
        y0_valid_in = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(negedge clock);
        clear_flags = 1'b0;
    endtask

    int ovf_s[8] = '{2, 6, -2, -6, 2, 6, -2, -6};
    int lv[4]    = '{2, 6, -2, -6};
    int base;
    int rate;

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", {dac_sclk, dac_sdata, dac_frame, overflow_flag, underrun_flag}, 0);
        chk("reset_fill", fill_level, 0);
        reset = 1'b1;
        @(negedge clock);

        // Prime and stream
        enable = 1'b1;
        push(6); push(2); push(-2); push(-6);
        chk("prime_fill", fill_level, 4);
        chk("prime_no_frame_yet", dac_frame, 0);
        @(negedge clock);
        chk("first_frame_flag", dac_frame, 1);
        chk("first_msb", dac_sdata, 0);
        chk("fill_after_start", fill_level, 3);

        // Underrun zero frame, then a late push
        repeat (64) @(negedge clock);
        chk("underrun_flag", underrun_flag, 1);
        chk("underrun_frame", dac_frame, 1);
        push(2);
        repeat (32) @(negedge clock);
        chk("frame_count", got_frames.size(), 6);
        chk_frame("frame0", 0, 4'b0110);
        chk_frame("frame1", 1, 4'b0010);
        chk_frame("frame2", 2, 4'b1110);
        chk_frame("frame3", 3, 4'b1010);
        chk_frame("frame4_zero", 4, 4'b0000);
        chk_frame("frame5_late", 5, 4'b0010);

        enable = 1'b0;
        repeat (20) @(negedge clock);
        pulse_clear();
        chk("udr_cleared", underrun_flag, 0);

        // Overflow while idle
        for (int i = 0; i < 8; i++) push(ovf_s[i]);
        push(6);
        chk("ovf_fill", fill_level, 8);
        chk("ovf_flag", overflow_flag, 1);
        pulse_clear();
        chk("ovf_cleared", overflow_flag, 0);
        clear_flags = 1'b1;
        push(6);
        clear_flags = 1'b0;
        chk("ovf_set_beats_clear", overflow_flag, 1);
        pulse_clear();
        base = got_frames.size();

        // Full FIFO: pushes coincident with pops are accepted
        enable = 1'b1;
        push(-2);
        chk("full_pop_push_fill", fill_level, 8);
        chk("full_pop_push_ovf", overflow_flag, 0);
        repeat (15) @(negedge clock);
        push(2);
        chk("boundary_push_fill", fill_level, 8);
        chk("boundary_push_ovf", overflow_flag, 0);

        // Disable mid-frame
        repeat (4) @(negedge clock);
        enable = 1'b0;
        repeat (11) @(negedge clock);
        chk("last_bit_sclk", dac_sclk, 1);
        @(negedge clock);
        chk("drain_outputs", {dac_sclk, dac_sdata, dac_frame}, 0);
        chk("drain_fill", fill_level, 8);
        @(negedge clock);
        chk_frame("stream_ovf0", base, ovf_s[0]);
        chk_frame("stream_ovf1", base + 1, ovf_s[1]);
        chk("no_truncated_extra", got_frames.size(), base + 2);

        // Async reset mid-frame
        enable = 1'b1;
        repeat (6) @(negedge clock);
        chk("pre_reset_sdata", dac_sdata, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", {dac_sclk, dac_sdata, dac_frame, overflow_flag, underrun_flag}, 0);
        chk("async_reset_fill", fill_level, 0);
        reset = 1'b1;
        push(6); push(-6); push(2);
        repeat (10) @(negedge clock);
        chk("unprimed_idle", {dac_sclk, dac_frame}, 0);
        chk("unprimed_fill", fill_level, 3);
        push(-2);
        @(negedge clock);
        chk("reprimed_frame", dac_frame, 1);

        // Randomised traffic with varying input rates
        for (int seg = 0; seg < 20; seg++) begin
            rate = $urandom_range(30, 4);
            for (int c = 0; c < 150; c++) begin
                y0_valid_in = ($urandom_range(rate - 1) == 0);
                y0_data_in  = lv[$urandom_range(3)][IN_W-1:0];
                clear_flags = ($urandom_range(79) == 0);
                if ($urandom_range(149) == 0) enable = ~enable;
                @(negedge clock);
            end
        end
        y0_valid_in = 1'b0;
        clear_flags = 1'b0;
        repeat (5) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
